// File: rtl/vga_pkg.sv
// Shared VGA timing constants and motion-controller encodings.
//   VGA_H_ACTIVE / VGA_V_ACTIVE : visible raster size
//   motion_state_t + S_*        : motion FSM state encoding
//   dir_t + DIR_*               : axis direction encoding (INC = right/down)
//   next_color()                : bounce colour sequence 001..111, wrapping to 001
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_V_ACTIVE = 480;

  typedef logic [1:0] motion_state_t;
  localparam motion_state_t S_IDLE   = 2'd0;
  localparam motion_state_t S_STEP_X = 2'd1;
  localparam motion_state_t S_STEP_Y = 2'd2;

  typedef logic dir_t;
  localparam dir_t DIR_INC = 1'b0;  // RIGHT for X, DOWN for Y
  localparam dir_t DIR_DEC = 1'b1;  // LEFT for X, UP for Y

  // Black (000) is skipped so the logo never disappears on a bounce.
  function automatic logic [2:0] next_color(input logic [2:0] c);
    return (c == 3'b111) ? 3'b001 : c + 3'd1;
  endfunction

endpackage

// File: rtl/bounce_axis.sv
// One axis of the bouncing logo: position/direction register with the
// clamp-and-flip rule applied when stepped.
//   clk_i, rst_ni : clock, async active-low reset
//   step_i        : apply one STEP move this cycle
//   clr_i         : clear the sticky hit flag
//   pos_o         : current position (logo edge)
//   hit_o         : edge hit in the current update (sticky flag, or the hit
//                   being produced by a step in this very cycle)
module bounce_axis
  import vga_pkg::*;
#(
  parameter int W     = 10,
  parameter int MAX   = 576,
  parameter int STEP  = 1,
  parameter int START = 0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         step_i,
  input  logic         clr_i,
  output logic [W-1:0] pos_o,
  output logic         hit_o
);

  localparam logic [10:0]  MAX_L   = 11'(MAX);
  localparam logic [10:0]  STEP_L  = 11'(STEP);
  localparam logic [W-1:0] START_L = W'(START);

  logic [W-1:0] pos_q, pos_d;
  dir_t         dir_q, dir_d;
  logic         hit_q, hit_d;

  logic [10:0]  pos_ext;
  logic [10:0]  pos_nxt;
  dir_t         dir_nxt;
  logic         hit_nxt;

  // 11-bit arithmetic keeps pos+STEP from wrapping before the clamp compare.
  always_comb begin
    pos_ext = 11'(pos_q);
    pos_nxt = pos_ext;
    dir_nxt = dir_q;
    hit_nxt = 1'b0;
    if (dir_q == DIR_INC) begin
      if (pos_ext + STEP_L >= MAX_L) begin
        pos_nxt = MAX_L;
        dir_nxt = DIR_DEC;
        hit_nxt = 1'b1;
      end else begin
        pos_nxt = pos_ext + STEP_L;
      end
    end else begin
      if (pos_ext <= STEP_L) begin
        pos_nxt = 11'd0;
        dir_nxt = DIR_INC;
        hit_nxt = 1'b1;
      end else begin
        pos_nxt = pos_ext - STEP_L;
      end
    end
  end

  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    hit_d = hit_q;
    if (step_i) begin
      pos_d = pos_nxt[W-1:0];
      dir_d = dir_nxt;
      hit_d = hit_nxt;
    end else if (clr_i) begin
      hit_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pos_q <= START_L;
      dir_q <= DIR_INC;
      hit_q <= 1'b0;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
      hit_q <= hit_d;
    end
  end

  assign pos_o = pos_q;
  assign hit_o = hit_q | (step_i & hit_nxt);

endmodule

// File: rtl/logo_motion_controller.sv
// Frame-rate scheduler that bounces the logo around the visible area and
// maps the raster position into logo-relative coordinates.
//   clk_i, rst_ni            : pixel clock, async active-low reset
//   enable_i                 : motion enable (freezes divider and position)
//   vertical_active_video_i  : vertical active-video flag
//   x_i, y_i                 : raster counters
//   x_offset_o, y_offset_o   : logo top-left corner
//   rel_x_o, rel_y_o         : raster minus offset, one cycle latency
//   in_logo_o                : raster inside the logo box, one cycle latency
//   color_o                  : {r,g,b} logo colour
//   bounce_o, corner_o       : one-cycle pulses on edge / corner hits
module logo_motion_controller
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = VGA_H_ACTIVE,
  parameter int V_ACTIVE  = VGA_V_ACTIVE,
  parameter int LOGO_W    = 64,
  parameter int LOGO_H    = 64,
  parameter int STEP      = 1,
  parameter int FRAME_DIV = 1,
  parameter int X_START   = 0,
  parameter int Y_START   = 0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       enable_i,
  input  logic       vertical_active_video_i,
  input  logic [9:0] x_i,
  input  logic [8:0] y_i,
  output logic [9:0] x_offset_o,
  output logic [8:0] y_offset_o,
  output logic [9:0] rel_x_o,
  output logic [8:0] rel_y_o,
  output logic       in_logo_o,
  output logic [2:0] color_o,
  output logic       bounce_o,
  output logic       corner_o
);

  localparam logic [15:0] DIV_LAST = 16'(FRAME_DIV - 1);
  localparam logic [10:0] LOGO_W_L = 11'(LOGO_W);
  localparam logic [9:0]  LOGO_H_L = 10'(LOGO_H);

  // ---- frame tick: falling edge of vertical active video = vblank start
  logic vactive_q;
  logic tick;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) vactive_q <= 1'b0;
    else         vactive_q <= vertical_active_video_i;
  end

  assign tick = vactive_q & ~vertical_active_video_i;

  // ---- frame divider and motion FSM
  logic [15:0]   cnt_q, cnt_d;
  motion_state_t state_q, state_d;
  logic [2:0]    color_q, color_d;
  logic          bounce_q, bounce_d;
  logic          corner_q, corner_d;
  logic          update;
  logic          hit_x, hit_y;

  always_comb begin
    cnt_d    = cnt_q;
    state_d  = state_q;
    color_d  = color_q;
    bounce_d = 1'b0;
    corner_d = 1'b0;
    update   = 1'b0;

    // Ticks are only counted in S_IDLE; a stray tick mid-update is dropped.
    if (tick && enable_i && state_q == S_IDLE) begin
      if (cnt_q == DIV_LAST) begin
        cnt_d  = 16'd0;
        update = 1'b1;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (update) state_d = S_STEP_X;
      end
      S_STEP_X: state_d = S_STEP_Y;
      S_STEP_Y: begin
        state_d = S_IDLE;
        if (hit_x || hit_y) begin
          bounce_d = 1'b1;
          color_d  = next_color(color_q);
        end
        corner_d = hit_x & hit_y;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= 16'd0;
      state_q  <= S_IDLE;
      color_q  <= 3'b111;
      bounce_q <= 1'b0;
      corner_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      color_q  <= color_d;
      bounce_q <= bounce_d;
      corner_q <= corner_d;
    end
  end

  // ---- per-axis position registers (X stepped first, then Y)
  logic clr_hits;
  assign clr_hits = (state_q == S_IDLE);

  bounce_axis #(
    .W     (10),
    .MAX   (H_ACTIVE - LOGO_W),
    .STEP  (STEP),
    .START (X_START)
  ) u_axis_x (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .step_i (state_q == S_STEP_X),
    .clr_i  (clr_hits),
    .pos_o  (x_offset_o),
    .hit_o  (hit_x)
  );

  bounce_axis #(
    .W     (9),
    .MAX   (V_ACTIVE - LOGO_H),
    .STEP  (STEP),
    .START (Y_START)
  ) u_axis_y (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .step_i (state_q == S_STEP_Y),
    .clr_i  (clr_hits),
    .pos_o  (y_offset_o),
    .hit_o  (hit_y)
  );

  // ---- pixel path: one register stage, matched by delayed sync flags upstream
  logic [9:0] rel_x_q, rel_x_d;
  logic [8:0] rel_y_q, rel_y_d;
  logic       in_logo_q, in_logo_d;
  logic [10:0] x_ext, xo_ext;
  logic [9:0]  y_ext, yo_ext;

  always_comb begin
    x_ext     = 11'(x_i);
    xo_ext    = 11'(x_offset_o);
    y_ext     = 10'(y_i);
    yo_ext    = 10'(y_offset_o);
    rel_x_d   = x_i - x_offset_o;
    rel_y_d   = y_i - y_offset_o;
    in_logo_d = (x_ext >= xo_ext) && (x_ext < xo_ext + LOGO_W_L) &&
                (y_ext >= yo_ext) && (y_ext < yo_ext + LOGO_H_L);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rel_x_q   <= 10'd0;
      rel_y_q   <= 9'd0;
      in_logo_q <= 1'b0;
    end else begin
      rel_x_q   <= rel_x_d;
      rel_y_q   <= rel_y_d;
      in_logo_q <= in_logo_d;
    end
  end

  assign rel_x_o   = rel_x_q;
  assign rel_y_o   = rel_y_q;
  assign in_logo_o = in_logo_q;
  assign color_o   = color_q;
  assign bounce_o  = bounce_q;
  assign corner_o  = corner_q;

endmodule
